// File: rtl/io_sys_update_pkg.sv
// Shared types and constants for the remote-system-update controller.
// Offsets are relative to the IO base; sizes are byte counts on the IO strobe.
package io_sys_update_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StBootIss  = 4'd1,
    StBootWait = 4'd2,
    StAddrIss  = 4'd3,
    StAddrWait = 4'd4,
    StReady    = 4'd5,
    StHostIss  = 4'd6,
    StHostWait = 4'd7,
    StReconfig = 4'd8
  } st_t;

  localparam logic [3:0] OffCtrl = 4'd0;
  localparam logic [3:0] OffOper = 4'd1;
  localparam logic [3:0] OffStat = 4'd1;
  localparam logic [3:0] OffSel  = 4'd2;
  localparam logic [3:0] OffKey  = 4'd3;
  localparam logic [3:0] OffData = 4'd4;
  localparam logic [3:0] OffBoot = 4'd8;
  localparam logic [3:0] OffWdog = 4'd12;

  localparam logic [3:0] SzByte  = 4'd1;
  localparam logic [3:0] SzDword = 4'd4;

  localparam logic [7:0] KeyVal = 8'hA5;

  localparam int StatBusy  = 0;
  localparam int StatReady = 1;
  localparam int StatErr   = 2;
  localparam int StatOvf   = 3;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] param;
  } sel_t;

endpackage

// File: rtl/rsu_wdog_timer.sv
// Programmable watchdog: counts 0..period and emits a one-cycle registered kick, so the
// kick period is period+1 cycles; disabled, zero period or a period reload clears the count.
module rsu_wdog_timer #(
  parameter int CWdogW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              enable,
  input  logic              clear,
  input  logic [CWdogW-1:0] period,
  output logic              pulse
);

  logic [CWdogW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (en) begin
      if (clear || !enable || (period == '0)) begin
        cnt   <= '0;
        pulse <= 1'b0;
      end else if (cnt >= period) begin
        // >= keeps a lowered period from waiting for a full counter wrap
        cnt   <= '0;
        pulse <= 1'b1;
      end else begin
        cnt   <= cnt + CWdogW'(1);
        pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_sys_update_ctrl.sv
// RSU controller: reads boot mode/address after reset, then runs host param ops from IO.
// IO reads are combinational; host status is polled (never stalls the bus).
module io_sys_update_ctrl
  import io_sys_update_pkg::*;
#(
  parameter logic [15:0] CAddrBase  = 16'h0000,
  parameter int          CDataW     = 32,
  parameter int          CAddrW     = 32,
  parameter logic [2:0]  CModeParam = 3'h0,
  parameter logic [2:0]  CAddrParam = 3'h4,
  parameter int          CTimeoutW  = 12,
  parameter int          CWdogW     = 24
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic [15:0]       AIoAddr,
  output logic [63:0]       AIoMiso,
  input  logic [63:0]       AIoMosi,
  input  logic [3:0]        AIoWrSize,
  input  logic [3:0]        AIoRdSize,
  output logic              AIoAddrAck,
  output logic              AIoAddrErr,
  output logic              AIoBusy,
  input  logic              ARsuBusy,
  input  logic [CDataW-1:0] ARsuMiso,
  output logic [CDataW-1:0] ARsuMosi,
  output logic [2:0]        ARsuParam,
  output logic [1:0]        ARsuSrc,
  output logic              ARsuRdParam,
  output logic              ARsuWrParam,
  output logic              ARsuReconfig,
  output logic              ARsuResetTimer,
  output logic              ARsuReady,
  output logic [1:0]        ARsuMode,
  output logic [CAddrW-1:0] ARsuBootAddr,
  output logic [7:0]        ATest
);

  logic             io_rd, io_wr, hit, legal, wr_ok, rd_ok;
  logic [3:0]       off;
  logic             wr_ctrl, wr_oper, wr_sel, wr_key, wr_data, wr_wdog;
  st_t              state, state_n;
  logic [CTimeoutW-1:0] cnt;
  logic             in_wait, done, tmo, in_flight, busy;
  logic             pend, op_wr, err, ovf, ready, wdog_en;
  logic             oper_go, oper_ovf, clr, ctrl_req, grant, err_set;
  logic [7:0]       key;
  sel_t             sel;
  logic [CDataW-1:0] mosi_q, miso_q;
  logic [CWdogW-1:0] period;
  logic [1:0]       mode;
  logic [CAddrW-1:0] boot_addr;
  logic [3:0]       stat;
  logic             unused_mosi;

  assign io_rd = (AIoRdSize != 4'd0);
  assign io_wr = (AIoWrSize != 4'd0);
  assign off   = AIoAddr[3:0];
  assign hit   = (io_rd || io_wr) && (AIoAddr[15:4] == CAddrBase[15:4]);

  always_comb begin
    legal = 1'b0;
    if (io_wr && !io_rd) begin
      if (AIoWrSize == SzByte)       legal = off inside {OffCtrl, OffOper, OffSel, OffKey};
      else if (AIoWrSize == SzDword) legal = off inside {OffData, OffWdog};
    end else if (io_rd && !io_wr) begin
      if (AIoRdSize == SzByte)       legal = off inside {OffStat, OffSel};
      else if (AIoRdSize == SzDword) legal = off inside {OffData, OffBoot, OffWdog};
    end
  end

  assign AIoAddrAck = hit;
  assign AIoAddrErr = hit && !legal;
  assign AIoBusy    = 1'b0;
  assign wr_ok      = hit && legal && io_wr;
  assign rd_ok      = hit && legal && io_rd;

  assign wr_ctrl = wr_ok && (off == OffCtrl);
  assign wr_oper = wr_ok && (off == OffOper);
  assign wr_sel  = wr_ok && (off == OffSel);
  assign wr_key  = wr_ok && (off == OffKey);
  assign wr_data = wr_ok && (off == OffData);
  assign wr_wdog = wr_ok && (off == OffWdog);

  assign in_wait   = (state == StBootWait) || (state == StAddrWait) || (state == StHostWait);
  // cnt==0 guard gives the core one cycle to raise busy after the pulse
  assign done      = in_wait && (cnt != '0) && !ARsuBusy;
  assign tmo       = in_wait && !done && (&cnt);
  assign in_flight = (state == StHostIss) || (state == StHostWait);
  assign busy      = pend || in_flight;

  assign oper_go  = wr_oper && (AIoMosi[0] || AIoMosi[1]);
  assign oper_ovf = oper_go && busy;
  assign clr      = wr_oper && AIoMosi[7];
  assign ctrl_req = wr_ctrl && AIoMosi[0];
  assign grant    = ctrl_req && (key == KeyVal) && (state == StReady) && !pend;
  assign err_set  = tmo || (ctrl_req && !grant);

  always_comb begin
    state_n     = state;
    ARsuRdParam = 1'b0;
    ARsuWrParam = 1'b0;
    ARsuParam   = 3'd0;
    ARsuSrc     = 2'd0;
    case (state)
      StIdle:     state_n = StBootIss;
      StBootIss: begin
        ARsuRdParam = 1'b1;
        ARsuParam   = CModeParam;
        state_n     = StBootWait;
      end
      StBootWait: begin
        ARsuParam = CModeParam;
        if (done || tmo) state_n = StAddrIss;
      end
      StAddrIss: begin
        ARsuRdParam = 1'b1;
        ARsuParam   = CAddrParam;
        ARsuSrc     = (mode == 2'd0) ? 2'd0 : 2'd2;
        state_n     = StAddrWait;
      end
      StAddrWait: begin
        ARsuParam = CAddrParam;
        ARsuSrc   = (mode == 2'd0) ? 2'd0 : 2'd2;
        if (done || tmo) state_n = StReady;
      end
      StReady: begin
        if (pend)       state_n = StHostIss;
        else if (grant) state_n = StReconfig;
      end
      StHostIss: begin
        ARsuRdParam = !op_wr;
        ARsuWrParam = op_wr;
        ARsuParam   = sel.param;
        ARsuSrc     = sel.src;
        state_n     = StHostWait;
      end
      StHostWait: begin
        ARsuParam = sel.param;
        ARsuSrc   = sel.src;
        if (done || tmo) state_n = StReady;
      end
      StReconfig: state_n = StReconfig;
      default:    state_n = StIdle;
    endcase
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state     <= StIdle;
      cnt       <= '0;
      pend      <= 1'b0;
      op_wr     <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      ready     <= 1'b0;
      wdog_en   <= 1'b0;
      key       <= 8'd0;
      sel       <= '0;
      mosi_q    <= '0;
      miso_q    <= '0;
      period    <= '0;
      mode      <= 2'd0;
      boot_addr <= '0;
    end else if (AClkHEn) begin
      state <= state_n;
      cnt   <= in_wait ? cnt + CTimeoutW'(1) : '0;
      if (wr_ctrl) begin
        key     <= 8'd0;
        wdog_en <= AIoMosi[1];
      end else if (wr_key) begin
        key <= AIoMosi[7:0];
      end
      if (wr_sel)  sel    <= sel_t'({AIoMosi[5:4], AIoMosi[2:0]});
      if (wr_data) mosi_q <= AIoMosi[CDataW-1:0];
      if (wr_wdog) period <= AIoMosi[CWdogW-1:0];
      if (oper_go && !oper_ovf) begin
        pend  <= 1'b1;
        op_wr <= AIoMosi[1];
      end else if ((state == StReady) && pend) begin
        pend <= 1'b0;
      end
      // a new event in the same cycle as a clear must survive it
      err <= err_set  || (err && !clr);
      ovf <= oper_ovf || (ovf && !clr);
      if ((state == StBootWait) && (done || tmo))
        mode <= done ? ARsuMiso[1:0] : 2'd0;
      if ((state == StAddrWait) && (done || tmo)) begin
        boot_addr <= done ? CAddrW'(ARsuMiso[CDataW-1:2]) : '0;
        ready     <= 1'b1;
      end
      if ((state == StHostWait) && done && !op_wr)
        miso_q <= ARsuMiso;
    end
  end

  always_comb begin
    stat            = 4'd0;
    stat[StatBusy]  = busy;
    stat[StatReady] = ready;
    stat[StatErr]   = err;
    stat[StatOvf]   = ovf;
  end

  always_comb begin
    AIoMiso = 64'd0;
    if (rd_ok) begin
      case (off)
        OffStat: AIoMiso = 64'(stat);
        OffSel:  AIoMiso = 64'({sel.src, 1'b0, sel.param});
        OffData: AIoMiso = 64'(miso_q);
        OffBoot: AIoMiso = 64'(boot_addr);
        OffWdog: AIoMiso = 64'(period);
        default: AIoMiso = 64'd0;
      endcase
    end
  end

  rsu_wdog_timer #(.CWdogW(CWdogW)) u_wdog (
    .clk    (AClkH),
    .rst    (AResetH),
    .en     (AClkHEn),
    .enable (wdog_en),
    .clear  (wr_wdog),
    .period (period),
    .pulse  (ARsuResetTimer)
  );

  assign ARsuMosi     = mosi_q;
  assign ARsuMode     = mode;
  assign ARsuBootAddr = boot_addr;
  assign ARsuReady    = ready;
  assign ARsuReconfig = (state == StReconfig);
  assign ATest        = {ARsuRdParam, ARsuBusy, ARsuSrc, (mode == 2'd3), ARsuParam};
  assign unused_mosi  = ^AIoMosi;

endmodule

// File: tb/tb_io_sys_update_ctrl.sv
// Bench for io_sys_update_ctrl: RSU core model with a pulse scoreboard, an IO register
// vector table, and hand sequences for host ops, reconfig, watchdog and busy timeout.
module tb_io_sys_update_ctrl;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic [15:0] io_addr;
  logic [63:0] io_miso, io_mosi;
  logic [3:0]  io_wr_size, io_rd_size;
  logic        io_addr_ack, io_addr_err, io_busy;
  logic        rsu_busy;
  logic [31:0] rsu_miso, rsu_mosi;
  logic [2:0]  rsu_param;
  logic [1:0]  rsu_src;
  logic        rd_param, wr_param, reconfig, reset_timer, rsu_ready;
  logic [1:0]  rsu_mode;
  logic [31:0] boot_addr;
  logic [7:0]  test_bus;

  always #5 clk = ~clk;

  io_sys_update_ctrl dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(clk_en),
    .AIoAddr(io_addr), .AIoMiso(io_miso), .AIoMosi(io_mosi),
    .AIoWrSize(io_wr_size), .AIoRdSize(io_rd_size),
    .AIoAddrAck(io_addr_ack), .AIoAddrErr(io_addr_err), .AIoBusy(io_busy),
    .ARsuBusy(rsu_busy), .ARsuMiso(rsu_miso), .ARsuMosi(rsu_mosi),
    .ARsuParam(rsu_param), .ARsuSrc(rsu_src),
    .ARsuRdParam(rd_param), .ARsuWrParam(wr_param),
    .ARsuReconfig(reconfig), .ARsuResetTimer(reset_timer),
    .ARsuReady(rsu_ready), .ARsuMode(rsu_mode), .ARsuBootAddr(boot_addr),
    .ATest(test_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // expected RSU pulses, pushed as stimulus is driven
  typedef struct packed {
    logic        wr;
    logic [2:0]  param;
    logic [1:0]  src;
    logic [31:0] mosi;
  } exp_t;
  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] rsu_data_q[$];
  logic [31:0] pend_val;
  int          rem;
  bit          stuck;

  always @(negedge clk) begin
    if (rst) begin
      rem      = 0;
      rsu_busy = stuck;
    end else begin
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          rsu_busy = stuck;
          rsu_miso = pend_val;
        end
      end
      if (rd_param || wr_param) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got rd=%0b wr=%0b param=%0d want no pulse", rd_param, wr_param, rsu_param);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_wr", wr_param, sb_e.wr);
          chk("sb_rd", rd_param, !sb_e.wr);
          chk("sb_param", rsu_param, sb_e.param);
          chk("sb_src", rsu_src, sb_e.src);
          if (sb_e.wr) chk("sb_mosi", rsu_mosi, sb_e.mosi);
        end
        rem      = 3;
        rsu_busy = 1'b1;
        if (rd_param && !stuck && rsu_data_q.size() > 0) pend_val = rsu_data_q.pop_front();
      end
    end
  end

  task automatic io(input logic [3:0] rsz, input logic [3:0] wsz, input logic [15:0] addr,
                    input logic [63:0] wd, output logic ack, output logic err, output logic [63:0] rdat);
    @(negedge clk);
    io_rd_size = rsz;
    io_wr_size = wsz;
    io_addr    = addr;
    io_mosi    = wd;
    #1;
    ack  = io_addr_ack;
    err  = io_addr_err;
    rdat = io_miso;
    @(posedge clk);
    #1;
    io_rd_size = 4'd0;
    io_wr_size = 4'd0;
    io_mosi    = 64'd0;
  endtask

  task automatic wr_reg(input logic [3:0] sz, input logic [3:0] off, input logic [63:0] d);
    logic a, e;
    logic [63:0] r;
    io(4'd0, sz, {12'h000, off}, d, a, e, r);
  endtask

  task automatic rd_reg(input logic [3:0] sz, input logic [3:0] off, output logic [63:0] r);
    logic a, e;
    io(sz, 4'd0, {12'h000, off}, 64'd0, a, e, r);
  endtask

  task automatic wait_idle(input string nm);
    logic [63:0] r;
    int n;
    n = 0;
    do begin
      rd_reg(4'd1, 4'd1, r);
      n++;
    end while (r[0] && n < 100);
    chk(nm, r[0], 1'b0);
  endtask

  typedef struct {
    logic [3:0]  rsz, wsz;
    logic [15:0] addr;
    logic [63:0] wd;
    logic        ack, err;
    logic [63:0] rdat;
  } vec_t;
  vec_t vt[16];

  initial begin
    logic [63:0] r;
    logic        a, e;
    int          n;
    int          t[$];

    vt[0]  = '{4'd0, 4'd1, 16'h0002, 64'h13,   1'b1, 1'b0, 64'h0};
    vt[1]  = '{4'd1, 4'd0, 16'h0002, 64'h0,    1'b1, 1'b0, 64'h13};
    vt[2]  = '{4'd0, 4'd4, 16'h0004, 64'hABCD, 1'b1, 1'b0, 64'h0};
    vt[3]  = '{4'd4, 4'd0, 16'h0004, 64'h0,    1'b1, 1'b0, 64'h12345678};
    vt[4]  = '{4'd4, 4'd0, 16'h0008, 64'h0,    1'b1, 1'b0, 64'h100000};
    vt[5]  = '{4'd1, 4'd0, 16'h0001, 64'h0,    1'b1, 1'b0, 64'h2};
    vt[6]  = '{4'd1, 4'd0, 16'h0000, 64'h0,    1'b1, 1'b1, 64'h0};
    vt[7]  = '{4'd0, 4'd4, 16'h0001, 64'h1,    1'b1, 1'b1, 64'h0};
    vt[8]  = '{4'd0, 4'd1, 16'h0005, 64'h1,    1'b1, 1'b1, 64'h0};
    vt[9]  = '{4'd1, 4'd0, 16'h0008, 64'h0,    1'b1, 1'b1, 64'h0};
    vt[10] = '{4'd4, 4'd0, 16'h0018, 64'h0,    1'b0, 1'b0, 64'h0};
    vt[11] = '{4'd1, 4'd1, 16'h0002, 64'h5,    1'b1, 1'b1, 64'h0};
    vt[12] = '{4'd0, 4'd4, 16'h0008, 64'hFFFF, 1'b1, 1'b1, 64'h0};
    vt[13] = '{4'd4, 4'd0, 16'h0008, 64'h0,    1'b1, 1'b0, 64'h100000};
    vt[14] = '{4'd1, 4'd0, 16'h0001, 64'h0,    1'b1, 1'b0, 64'h2};
    vt[15] = '{4'd0, 4'd1, 16'h0003, 64'h5A,   1'b1, 1'b0, 64'h0};

    rst = 1'b1; clk_en = 1'b1; stuck = 1'b0;
    io_addr = 16'd0; io_mosi = 64'd0; io_wr_size = 4'd0; io_rd_size = 4'd0;
    rsu_busy = 1'b0; rsu_miso = 32'd0; pend_val = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rsu_ready, 1'b0);
    chk("rst_mode", rsu_mode, 2'd0);
    chk("rst_bootaddr", boot_addr, 32'd0);
    chk("rst_rdparam", rd_param, 1'b0);
    chk("rst_reconfig", reconfig, 1'b0);
    chk("rst_timer", reset_timer, 1'b0);
    chk("rst_test", test_bus, 8'd0);
    chk("rst_mosi", rsu_mosi, 32'd0);
    chk("rst_ack", io_addr_ack, 1'b0);
    chk("rst_iobusy", io_busy, 1'b0);

    // boot: mode read -> 2, addr read with src=2, then the host read queued during boot
    sb_q.push_back('{1'b0, 3'd0, 2'd0, 32'd0});
    sb_q.push_back('{1'b0, 3'd4, 2'd2, 32'd0});
    sb_q.push_back('{1'b0, 3'd0, 2'd0, 32'd0});
    rsu_data_q.push_back(32'h2);
    rsu_data_q.push_back(32'h0040_0003);
    rsu_data_q.push_back(32'h1234_5678);
    @(negedge clk);
    rst = 1'b0;
    rd_reg(4'd1, 4'd1, r);
    chk("boot_stat0", r, 64'h0);
    wr_reg(4'd1, 4'd1, 64'h1);
    rd_reg(4'd1, 4'd1, r);
    chk("boot_stat_pend", r, 64'h1);
    n = 0;
    while (!rsu_ready && n < 200) begin @(negedge clk); n++; end
    chk("boot_ready", rsu_ready, 1'b1);
    chk("boot_mode", rsu_mode, 2'd2);
    chk("boot_addr", boot_addr, 32'h0010_0000);
    wait_idle("boot_hostrd_idle");

    for (int i = 0; i < 16; i++) begin
      io(vt[i].rsz, vt[i].wsz, vt[i].addr, vt[i].wd, a, e, r);
      chk($sformatf("vec%0d_ack", i), a, vt[i].ack);
      chk($sformatf("vec%0d_err", i), e, vt[i].err);
      chk($sformatf("vec%0d_rdat", i), r, vt[i].rdat);
    end

    // host write with Sel=0x13, Data=0xABCD; the second Oper is dropped as overrun
    sb_q.push_back('{1'b1, 3'd3, 2'd1, 32'h0000_ABCD});
    wr_reg(4'd1, 4'd1, 64'h2);
    wr_reg(4'd1, 4'd1, 64'h2);
    wait_idle("hostwr_idle");
    rd_reg(4'd1, 4'd1, r);
    chk("hostwr_stat_ovf", r, 64'hA);
    wr_reg(4'd1, 4'd1, 64'h80);
    rd_reg(4'd1, 4'd1, r);
    chk("ovf_clear", r, 64'h2);

    // reconfig request with the wrong key is denied
    wr_reg(4'd1, 4'd0, 64'h1);
    rd_reg(4'd1, 4'd1, r);
    chk("deny_stat_err", r, 64'h6);
    chk("deny_reconfig", reconfig, 1'b0);
    wr_reg(4'd1, 4'd1, 64'h80);

    // watchdog period 5 -> one kick every 6 cycles
    wr_reg(4'd4, 4'd12, 64'h5);
    wr_reg(4'd1, 4'd0, 64'h2);
    for (int c = 0; c < 100 && t.size() < 4; c++) begin
      @(negedge clk);
      if (reset_timer) t.push_back(c);
    end
    chk("wdog_count", t.size(), 4);
    for (int i = 1; i < t.size(); i++) chk($sformatf("wdog_gap%0d", i), t[i] - t[i-1], 6);
    wr_reg(4'd4, 4'd12, 64'h0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (reset_timer) n++;
    end
    chk("wdog_zero_period", n, 0);

    // keyed reconfig is granted and holds
    wr_reg(4'd1, 4'd3, 64'hA5);
    wr_reg(4'd1, 4'd0, 64'h1);
    chk("reconfig_set", reconfig, 1'b1);
    repeat (10) @(negedge clk);
    chk("reconfig_held", reconfig, 1'b1);
    rd_reg(4'd1, 4'd1, r);
    chk("reconfig_stat", r, 64'h2);

    // reset mid-operation, then RSU busy stuck: both waits time out to the fallback
    stuck = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rerst_reconfig", reconfig, 1'b0);
    chk("rerst_ready", rsu_ready, 1'b0);
    sb_q.push_back('{1'b0, 3'd0, 2'd0, 32'd0});
    sb_q.push_back('{1'b0, 3'd4, 2'd0, 32'd0});
    rst = 1'b0;
    n = 0;
    while (!rsu_ready && n < 9000) begin @(negedge clk); n++; end
    chk("tmo_ready", rsu_ready, 1'b1);
    chk("tmo_window", (n >= 8192 && n <= 8200), 1'b1);
    chk("tmo_mode", rsu_mode, 2'd0);
    chk("tmo_bootaddr", boot_addr, 32'd0);
    rd_reg(4'd1, 4'd1, r);
    chk("tmo_stat_err", r, 64'h6);

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
